// File: rtl/pitch_band_classifier_if.sv
// Frame-stream bus between the FFT pitch detector (master) and the band classifier (slave).
// Carries the qualified dominant-bin sample in and the committed band code back out.
interface pitch_band_classifier_if #(
  parameter int BIN_W = 10
);
  logic [BIN_W-1:0] pitch_data;
  logic             pitch_valid;
  logic [1:0]       freq_flag;
  logic             flag_changed;

  modport master (
    output pitch_data,
    output pitch_valid,
    input  freq_flag,
    input  flag_changed
  );

  modport slave (
    input  pitch_data,
    input  pitch_valid,
    output freq_flag,
    output flag_changed
  );
endinterface

// File: rtl/pitch_band_classifier.sv
// Turns per-frame dominant FFT bins into a debounced 2-bit band code with edge hysteresis.
// Optional silence decay to band 0 is built only when PBC_SILENCE_TIMEOUT_EN is defined.
module pitch_band_classifier #(
  parameter int BIN_W          = 10,
  parameter int LOW_EDGE       = 4,
  parameter int MID_EDGE       = 11,
  parameter int HIGH_EDGE      = 22,
  parameter int HYST           = 1,
  parameter int CONFIRM        = 4,
  parameter int TIMEOUT_CYCLES = 18432000
) (
  input  logic                    clk,
  input  logic                    reset,
  pitch_band_classifier_if.slave  bus
);

  localparam int CNT_W = (CONFIRM < 1) ? 1 : $clog2(CONFIRM + 1);

  localparam logic [BIN_W-1:0] LOW_B  = BIN_W'(LOW_EDGE);
  localparam logic [BIN_W-1:0] MID_B  = BIN_W'(MID_EDGE);
  localparam logic [BIN_W-1:0] HIGH_B = BIN_W'(HIGH_EDGE);

  localparam logic [BIN_W:0] LOW_X  = (BIN_W + 1)'(LOW_EDGE);
  localparam logic [BIN_W:0] MID_X  = (BIN_W + 1)'(MID_EDGE);
  localparam logic [BIN_W:0] HIGH_X = (BIN_W + 1)'(HIGH_EDGE);
  localparam logic [BIN_W:0] HYST_X = (BIN_W + 1)'(HYST);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CONFIRM);

  // Reject parameter sets where a band is narrower than the hysteresis margin.
  if ((CONFIRM < 1) || (TIMEOUT_CYCLES < 1) || (HYST >= LOW_EDGE) ||
      (HYST >= (MID_EDGE - LOW_EDGE)) || (HYST >= (HIGH_EDGE - MID_EDGE)) ||
      (HYST >= ((1 << BIN_W) - HIGH_EDGE))) begin : g_bad_param
    $error("pitch_band_classifier: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    TRACK   = 1'b0,
    PENDING = 1'b1
  } state_e;

  function automatic logic [1:0] classify(input logic [BIN_W-1:0] bin);
    logic [1:0] band;
    if (bin < LOW_B) begin
      band = 2'd0;
    end else if (bin < MID_B) begin
      band = 2'd1;
    end else if (bin < HIGH_B) begin
      band = 2'd2;
    end else begin
      band = 2'd3;
    end
    return band;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       flag_q, flag_d;
  logic             changed_q, changed_d;

  logic [BIN_W:0]   pitch_ext_s;
  logic [1:0]       raw_s;
  logic [1:0]       candidate_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic [1:0]       cand_next_s;

`ifdef PBC_SILENCE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_expire_s;

  // Idle-cycle counter: saturates at the timeout, cleared by any valid sample.
  always_comb begin
    tmo_d        = tmo_q;
    tmo_expire_s = 1'b0;
    if (bus.pitch_valid) begin
      tmo_d = {TMO_W{1'b0}};
    end else if (tmo_q != TMO_SAT) begin
      tmo_d        = tmo_q + TMO_W'(1);
      tmo_expire_s = (tmo_q == TMO_LAST);
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= {TMO_W{1'b0}};
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  // Candidate band: move away from the committed band only once past the edge by HYST.
  always_comb begin
    pitch_ext_s = {1'b0, bus.pitch_data};
    raw_s       = classify(bus.pitch_data);
    candidate_s = flag_q;
    case (flag_q)
      2'd0: begin
        if (pitch_ext_s >= LOW_X + HYST_X) begin
          candidate_s = raw_s;
        end else begin
          candidate_s = flag_q;
        end
      end
      2'd1: begin
        if (pitch_ext_s >= MID_X + HYST_X) begin
          candidate_s = raw_s;
        end else if (pitch_ext_s + HYST_X < LOW_X) begin
          candidate_s = raw_s;
        end else begin
          candidate_s = flag_q;
        end
      end
      2'd2: begin
        if (pitch_ext_s >= HIGH_X + HYST_X) begin
          candidate_s = raw_s;
        end else if (pitch_ext_s + HYST_X < MID_X) begin
          candidate_s = raw_s;
        end else begin
          candidate_s = flag_q;
        end
      end
      2'd3: begin
        if (pitch_ext_s + HYST_X < HIGH_X) begin
          candidate_s = raw_s;
        end else begin
          candidate_s = flag_q;
        end
      end
      default: candidate_s = flag_q;
    endcase
  end

  // Confirmation FSM: a band change commits after CONFIRM consecutive agreeing samples.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    flag_d      = flag_q;
    changed_d   = 1'b0;
    cnt_next_s  = CNT_ONE;
    cand_next_s = candidate_s;

    if (bus.pitch_valid) begin
      if (candidate_s == flag_q) begin
        state_d = TRACK;
        cnt_d   = CNT_ZERO;
      end else begin
        case (state_q)
          TRACK: begin
            cnt_next_s = CNT_ONE;
          end
          PENDING: begin
            if (candidate_s == cand_q) begin
              cnt_next_s = cnt_q + CNT_ONE;
            end else begin
              cnt_next_s = CNT_ONE;
            end
          end
          default: begin
            cnt_next_s = CNT_ONE;
          end
        endcase

        cand_d = cand_next_s;
        if (cnt_next_s == CNT_DONE) begin
          flag_d    = cand_next_s;
          changed_d = 1'b1;
          cnt_d     = CNT_ZERO;
          state_d   = TRACK;
        end else begin
          cnt_d   = cnt_next_s;
          state_d = PENDING;
        end
      end
    end else begin
`ifdef PBC_SILENCE_TIMEOUT_EN
      if (tmo_expire_s) begin
        flag_d    = 2'd0;
        changed_d = (flag_q != 2'd0);
        cnt_d     = CNT_ZERO;
        state_d   = TRACK;
      end else begin
        flag_d = flag_q;
      end
`endif
    end
  end

  // State, pending-candidate and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= TRACK;
      cand_q    <= 2'd0;
      cnt_q     <= CNT_ZERO;
      flag_q    <= 2'd0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      flag_q    <= flag_d;
      changed_q <= changed_d;
    end
  end

  assign bus.freq_flag    = flag_q;
  assign bus.flag_changed = changed_q;

endmodule

// File: tb/tb_pitch_band_classifier.sv
// Directed plus randomized bench for pitch_band_classifier against a frame-level reference model.
// TIMEOUT_CYCLES is shrunk to 100 so the silence-decay build can be exercised quickly.
module tb_pitch_band_classifier;

  localparam int BIN_W     = 10;
  localparam int LOW_EDGE  = 4;
  localparam int MID_EDGE  = 11;
  localparam int HIGH_EDGE = 22;
  localparam int HYST      = 1;
  localparam int CONFIRM   = 4;
  localparam int TMO       = 100;
`ifdef PBC_SILENCE_TIMEOUT_EN
  localparam bit TMO_EN    = 1'b1;
`else
  localparam bit TMO_EN    = 1'b0;
`endif

  logic clk;
  logic reset;

  pitch_band_classifier_if #(.BIN_W(BIN_W)) bus ();

  pitch_band_classifier #(
    .BIN_W(BIN_W), .LOW_EDGE(LOW_EDGE), .MID_EDGE(MID_EDGE), .HIGH_EDGE(HIGH_EDGE),
    .HYST(HYST), .CONFIRM(CONFIRM), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  int    pulses   = 0;
  string phase    = "init";

  // Reference model: committed band, the band currently being confirmed (-1 none), its streak.
  int m_flag = 0;
  int m_pend = -1;
  int m_run  = 0;
  int m_idle = 0;
  int m_chg  = 0;

  function automatic int raw_band(input int b);
    if (b < LOW_EDGE)  return 0;
    if (b < MID_EDGE)  return 1;
    if (b < HIGH_EDGE) return 2;
    return 3;
  endfunction

  function automatic int lower_edge(input int band);
    if (band == 1) return LOW_EDGE;
    if (band == 2) return MID_EDGE;
    return HIGH_EDGE;
  endfunction

  // Target band for one sample given the committed band f.
  function automatic int target(input int f, input int b);
    if (f < 3 && b >= lower_edge(f + 1) + HYST) return raw_band(b);
    if (f > 0 && b + HYST < lower_edge(f))      return raw_band(b);
    return f;
  endfunction

  task automatic model_clock(input bit rst, input bit v, input int b);
    int t;
    m_chg = 0;
    if (rst) begin
      m_flag = 0; m_pend = -1; m_run = 0; m_idle = 0;
    end else if (v) begin
      m_idle = 0;
      t = target(m_flag, b);
      if (t == m_flag) begin
        m_pend = -1; m_run = 0;
      end else begin
        if (t == m_pend) m_run++;
        else begin m_pend = t; m_run = 1; end
        if (m_run == CONFIRM) begin
          m_chg = 1; m_flag = t; m_pend = -1; m_run = 0;
        end
      end
    end else if (TMO_EN && m_idle < TMO) begin
      m_idle++;
      if (m_idle == TMO) begin
        if (m_flag != 0) m_chg = 1;
        m_flag = 0; m_pend = -1; m_run = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input int exp);
    n_checks++;
    assert (obs === 2'(exp)) else begin
      n_errors++;
      $error("FAIL %s [%s]: observed %0d expected %0d", tag, phase, obs, exp);
    end
  endtask

  // One clock: drive, let the edge sample, advance the model, compare both outputs.
  task automatic step(input bit rst, input bit v, input int b);
    reset           = rst;
    bus.pitch_valid = v;
    bus.pitch_data  = BIN_W'(b);
    @(posedge clk);
    model_clock(rst, v, b);
    #1;
    check("freq_flag", bus.freq_flag, m_flag);
    check("flag_changed", {1'b0, bus.flag_changed}, m_chg);
    if (bus.flag_changed === 1'b1) pulses++;
  endtask

  task automatic feed(input int b, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, b);
  endtask

  initial begin
    int b, run, sel;
    reset = 1'b1; bus.pitch_valid = 1'b0; bus.pitch_data = '0;

    phase = "reset";
    step(1'b1, 1'b1, 30);
    step(1'b1, 1'b1, 30);
    check("reset_flag", bus.freq_flag, 0);

    phase = "confirm";
    pulses = 0;
    feed(15, 3);
    check("pre_commit_flag", bus.freq_flag, 0);
    feed(15, 1);
    check("commit_flag", bus.freq_flag, 2);
    step(1'b0, 1'b0, 0);
    check("commit_pulse_count", 2'(pulses), 1);

    phase = "broken_run";
    step(1'b1, 1'b0, 0);
    feed(15, 3); feed(2, 1); feed(15, 3);
    check("broken_run_flag", bus.freq_flag, 0);

    phase = "hyst_up";
    feed(15, 1);
    check("reach_band2", bus.freq_flag, 2);
    feed(22, 8);
    check("hold_at_22", bus.freq_flag, 2);
    feed(23, 4);
    check("up_to_3", bus.freq_flag, 3);

    phase = "hyst_down";
    feed(21, 8);
    check("hold_at_21", bus.freq_flag, 3);
    feed(20, 4);
    check("down_to_2", bus.freq_flag, 2);

    phase = "replace";
    step(1'b1, 1'b0, 0);
    pulses = 0;
    feed(15, 2); feed(30, 3);
    check("replace_pending", bus.freq_flag, 0);
    feed(30, 1);
    check("replace_commit", bus.freq_flag, 3);
    check("replace_pulses", 2'(pulses), 1);

    phase = "timeout";
    pulses = 0;
    for (int i = 0; i < (TMO_EN ? TMO : 1000); i++) step(1'b0, 1'b0, 0);
    check("idle_flag", bus.freq_flag, TMO_EN ? 0 : 3);
    check("idle_pulses", 2'(pulses), TMO_EN ? 1 : 0);

    phase = "reset_mid";
    step(1'b1, 1'b0, 0);
    feed(30, 3);
    step(1'b1, 1'b1, 30);
    pulses = 0;
    feed(30, 1);
    check("reset_mid_flag", bus.freq_flag, 0);
    check("reset_mid_pulses", 2'(pulses), 0);

    phase = "random";
    for (int it = 0; it < 600; it++) begin
      sel = $urandom_range(0, 99);
      if (sel < 2) begin
        step(1'b1, 1'b1, $urandom_range(0, 1023));
      end else if (sel < 5) begin
        run = $urandom_range(TMO - 10, TMO + 20);
        for (int i = 0; i < run; i++) step(1'b0, 1'b0, $urandom_range(0, 1023));
      end else begin
        case ($urandom_range(0, 3))
          0:       b = LOW_EDGE  + $urandom_range(0, 6) - 3;
          1:       b = MID_EDGE  + $urandom_range(0, 6) - 3;
          2:       b = HIGH_EDGE + $urandom_range(0, 6) - 3;
          default: b = $urandom_range(0, 1023);
        endcase
        if (b < 0) b = 0;
        run = $urandom_range(1, 6);
        for (int i = 0; i < run; i++) step(1'b0, ($urandom_range(0, 9) < 8), b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
